block_map_read_arbiter: RTL and testbench

//  Shares the single synchronous read port of the arena block_map RAM among N_REQ requesters.

---
 rtl/bm_pkg.sv | 22 ++
 rtl/block_map_read_arbiter_if.sv | 30 +++
 rtl/block_map_read_arbiter_rr_priority_select.sv | 27 ++
 rtl/block_map_read_arbiter.sv | 89 ++++++++
 tb/tb_block_map_read_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bm_pkg.sv
// rtl/bm_pkg.sv - shared block_map constants, tile codes and arbiter state encodings
package bm_pkg;

    localparam int ARENA_W   = 25;
    localparam int ARENA_H   = 20;
    localparam int BM_ADDR_W = 9;

    typedef enum logic [1:0] {
        TILE_EMPTY  = 2'd0,
        TILE_PILLAR = 2'd1,
        TILE_WALL   = 2'd2
    } tile_t;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/block_map_read_arbiter_if.sv
// rtl/block_map_read_arbiter_if.sv - requester/RAM side bundle of the block_map read arbiter
interface block_map_read_arbiter_if
    import bm_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = BM_ADDR_W,
    parameter int DATA_W = 2
);
    localparam int GID_W = idx_width(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] addr_flat;
    logic [ADDR_W-1:0]       ram_addr;
    logic [DATA_W-1:0]       ram_rdata;
    logic [N_REQ-1:0]        ack;
    logic [DATA_W-1:0]       rdata;
    logic [GID_W-1:0]        grant_id;
    logic                    busy;

    modport master (
        output req, addr_flat, ram_rdata,
        input  ram_addr, ack, rdata, grant_id, busy
    );

    modport slave (
        input  req, addr_flat, ram_rdata,
        output ram_addr, ack, rdata, grant_id, busy
    );

endinterface

// File: rtl/block_map_read_arbiter_rr_priority_select.sv
// rtl/block_map_read_arbiter_rr_priority_select.sv - combinational round-robin pick starting at ptr
module rr_priority_select #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the farthest candidate back to ptr so the closest requester wins last.
    always_comb begin
        int j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (req[j]) begin
                valid = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/block_map_read_arbiter.sv
// rtl/block_map_read_arbiter.sv - round-robin sharing of the block_map synchronous read port
module block_map_read_arbiter
    import bm_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = BM_ADDR_W,
    parameter int DATA_W = 2,
    parameter int RD_LAT = 1
) (
    input logic                     clk,
    input logic                     reset,
    block_map_read_arbiter_if.slave bus
);

    localparam int         GID_W    = idx_width(N_REQ);
    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    logic [1:0]        state;
    logic [1:0]        lat_cnt;
    logic [GID_W-1:0]  ptr;
    logic [GID_W-1:0]  gid;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] rdata;
    logic [N_REQ-1:0]  ack;
    logic              sel_valid;
    logic [GID_W-1:0]  sel_idx;

    rr_priority_select #(
        .N_REQ (N_REQ),
        .IDX_W (GID_W)
    ) u_sel (
        .req   (bus.req),
        .ptr   (ptr),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    // CAPTURE spans two clocks: first edge registers data and raises ack, second clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            ptr      <= '0;
            gid      <= '0;
            ram_addr <= '0;
            rdata    <= '0;
            ack      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        gid      <= sel_idx;
                        ram_addr <= bus.addr_flat[sel_idx*ADDR_W +: ADDR_W];
                        lat_cnt  <= LAT_INIT;
                        ptr      <= (sel_idx == GID_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    if (ack == '0) begin
                        rdata <= bus.ram_rdata;
                        ack   <= N_REQ'(1) << gid;
                    end else begin
                        ack   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    ack   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ram_addr = ram_addr;
    assign bus.ack      = ack;
    assign bus.rdata    = rdata;
    assign bus.grant_id = gid;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_block_map_read_arbiter.sv
// tb/tb_block_map_read_arbiter.sv - randomized and directed checks of block_map_read_arbiter
module tb_block_map_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 9;
    localparam int DW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    block_map_read_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus0 ();
    block_map_read_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus1 ();

    block_map_read_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_arb0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    block_map_read_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_arb1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    logic [DW-1:0]   mem [0:511];
    logic [N-1:0]    req_d [2];
    logic [N*AW-1:0] addr_d [2];
    logic [DW-1:0]   p0;
    logic [DW-1:0]   p1 [3];

    always @(posedge clk) begin
        p0    <= mem[bus0.ram_addr];
        p1[0] <= mem[bus1.ram_addr];
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end

    assign bus0.req       = req_d[0];
    assign bus0.addr_flat = addr_d[0];
    assign bus0.ram_rdata = p0;
    assign bus1.req       = req_d[1];
    assign bus1.addr_flat = addr_d[1];
    assign bus1.ram_rdata = p1[2];

    logic [N-1:0]  ack_o   [2];
    logic [DW-1:0] rdata_o [2];
    logic [1:0]    gid_o   [2];
    logic [AW-1:0] raddr_o [2];
    logic          busy_o  [2];

    assign ack_o[0]   = bus0.ack;
    assign rdata_o[0] = bus0.rdata;
    assign gid_o[0]   = bus0.grant_id;
    assign raddr_o[0] = bus0.ram_addr;
    assign busy_o[0]  = bus0.busy;
    assign ack_o[1]   = bus1.ack;
    assign rdata_o[1] = bus1.rdata;
    assign gid_o[1]   = bus1.grant_id;
    assign raddr_o[1] = bus1.ram_addr;
    assign busy_o[1]  = bus1.busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit auto_drop [2];

    // Reference: a read granted at edge n acks at n+LAT+1, keeps busy to n+LAT+2, next grant at n+LAT+3.
    int            lat     [2];
    int            gedge   [2];
    int            free_at [2];
    int            ptr_m   [2];
    int            gid_m   [2];
    logic [AW-1:0] addr_m  [2];
    logic [DW-1:0] data_m  [2];
    logic [DW-1:0] rdata_m [2];

    int got_id [$];
    int got_at [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            gedge[i]   = -1000;
            free_at[i] = 0;
            ptr_m[i]   = 0;
            gid_m[i]   = 0;
            addr_m[i]  = '0;
            data_m[i]  = '0;
            rdata_m[i] = '0;
        end
    endtask

    task automatic model_edge(input int i, input int n);
        bit found;
        int g;
        found = 0;
        g = 0;
        if (!reset && n >= free_at[i] && req_d[i] != '0) begin
            for (int k = 0; k < N; k++) begin
                if (!found && req_d[i][(ptr_m[i] + k) % N]) begin
                    found = 1;
                    g = (ptr_m[i] + k) % N;
                end
            end
            gedge[i]   = n;
            free_at[i] = n + lat[i] + 3;
            gid_m[i]   = g;
            addr_m[i]  = addr_d[i][g*AW +: AW];
            data_m[i]  = mem[addr_m[i]];
            ptr_m[i]   = (g + 1) % N;
        end
        if (!reset && n == gedge[i] + lat[i] + 1)
            rdata_m[i] = data_m[i];
    endtask

    task automatic check_inst(input int i);
        logic [N-1:0] exp_ack;
        logic         exp_busy;
        exp_ack  = (cyc == gedge[i] + lat[i] + 1) ? (N'(1) << gid_m[i]) : '0;
        exp_busy = (cyc >= gedge[i]) && (cyc < gedge[i] + lat[i] + 2);
        check($sformatf("ack%0d", i),   32'(ack_o[i]),   32'(exp_ack));
        check($sformatf("busy%0d", i),  32'(busy_o[i]),  32'(exp_busy));
        check($sformatf("rdata%0d", i), 32'(rdata_o[i]), 32'(rdata_m[i]));
        check($sformatf("gid%0d", i),   32'(gid_o[i]),   32'(gid_m[i]));
        check($sformatf("raddr%0d", i), 32'(raddr_o[i]), 32'(addr_m[i]));
    endtask

    task automatic tick();
        for (int i = 0; i < 2; i++) model_edge(i, cyc + 1);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_inst(i);
            if (auto_drop[i]) req_d[i] = req_d[i] & ~ack_o[i];
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) check_inst(i);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_addr(input int i, input int r, input logic [AW-1:0] a);
        addr_d[i][r*AW +: AW] = a;
    endtask

    task automatic collect(input int i, input int want, input string tag);
        int t;
        t = 0;
        got_id.delete();
        got_at.delete();
        while (got_id.size() < want && t < 20 * want) begin
            tick();
            t++;
            for (int r = 0; r < N; r++) begin
                if (ack_o[i][r]) begin
                    got_id.push_back(r);
                    got_at.push_back(cyc);
                end
            end
        end
        check({tag, "_count"}, 32'(got_id.size()), 32'(want));
    endtask

    initial begin
        int cnt;
        int exp3 [7];
        exp3 = '{1, 3, 1, 3, 0, 1, 3};
        lat[0] = 1;
        lat[1] = 3;
        for (int a = 0; a < 512; a++) mem[a] = DW'($urandom_range(0, 2));
        mem[9'h05A] = 2'd2;
        mem[9'h033] = 2'd1;
        mem[9'h1FF] = 2'd0;
        mem[9'h10A] = 2'd2;
        for (int i = 0; i < 2; i++) begin
            req_d[i]     = '0;
            addr_d[i]    = '0;
            auto_drop[i] = 1;
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) check_inst(i);
        reset = 1'b0;

        // Four simultaneous requesters, each dropping on its own ack.
        for (int r = 0; r < N; r++) set_addr(0, r, AW'($urandom));
        req_d[0] = 4'b1111;
        collect(0, 4, "t2");
        for (int k = 0; k < got_id.size(); k++) begin
            check($sformatf("t2_order%0d", k), 32'(got_id[k]), 32'(k));
            if (k > 0) check($sformatf("t2_space%0d", k), 32'(got_at[k] - got_at[k-1]), 32'd4);
        end

        // Two persistent requesters alternate; requester 0 joins once the pointer wraps.
        auto_drop[0] = 0;
        req_d[0] = 4'b1010;
        collect(0, 4, "t3a");
        req_d[0][0] = 1'b1;
        for (int k = 0; k < got_id.size(); k++)
            check($sformatf("t3_order%0d", k), 32'(got_id[k]), 32'(exp3[k]));
        collect(0, 3, "t3b");
        for (int k = 0; k < got_id.size(); k++)
            check($sformatf("t3_order%0d", k + 4), 32'(got_id[k]), 32'(exp3[k+4]));
        req_d[0] = '0;
        auto_drop[0] = 1;
        repeat (6) tick();

        // Single request: latency and data.
        set_addr(0, 2, 9'h05A);
        req_d[0] = 4'b0100;
        tick();
        check("t1_raddr", 32'(raddr_o[0]), 32'h05A);
        cnt = 0;
        while (ack_o[0] == '0 && cnt < 10) begin tick(); cnt++; end
        check("t1_latency", 32'(cnt), 32'd2);
        check("t1_ack", 32'(ack_o[0]), 32'b0100);
        check("t1_rdata", 32'(rdata_o[0]), 32'd2);
        tick();
        check("t1_busy", 32'(busy_o[0]), 32'd0);
        repeat (3) tick();

        // Granted requester withdraws and changes its address during WAIT.
        set_addr(0, 2, 9'h033);
        req_d[0] = 4'b0100;
        tick();
        req_d[0] = '0;
        set_addr(0, 2, 9'h1FF);
        tick();
        check("t4_raddr", 32'(raddr_o[0]), 32'h033);
        tick();
        check("t4_ack", 32'(ack_o[0]), 32'b0100);
        check("t4_rdata", 32'(rdata_o[0]), 32'(mem[9'h033]));
        repeat (3) tick();

        // Reset in WAIT aborts the read; lowest pending index wins after release.
        set_addr(0, 3, AW'($urandom));
        set_addr(0, 1, AW'($urandom));
        req_d[0] = 4'b1000;
        tick();
        req_d[0] = 4'b1010;
        apply_reset();
        check("t5_busy", 32'(busy_o[0]), 32'd0);
        check("t5_raddr", 32'(raddr_o[0]), 32'd0);
        tick();
        check("t5_gid", 32'(gid_o[0]), 32'd1);
        repeat (12) tick();
        req_d[0] = '0;
        repeat (4) tick();

        // Three-cycle RAM: single request.
        set_addr(1, 1, 9'h10A);
        req_d[1] = 4'b0010;
        tick();
        cnt = 0;
        while (ack_o[1] == '0 && cnt < 12) begin tick(); cnt++; end
        check("t6_latency", 32'(cnt), 32'd4);
        check("t6_rdata", 32'(rdata_o[1]), 32'(mem[9'h10A]));
        repeat (4) tick();

        // Randomized requesters on both builds.
        auto_drop[0] = 0;
        auto_drop[1] = 0;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < 2; i++) begin
                for (int r = 0; r < N; r++) begin
                    if (req_d[i][r]) begin
                        if (ack_o[i][r]) begin
                            if ($urandom_range(0, 3) != 0) req_d[i][r] = 1'b0;
                        end else if ($urandom_range(0, 31) == 0) begin
                            req_d[i][r] = 1'b0;
                        end
                        if ($urandom_range(0, 7) == 0) set_addr(i, r, AW'($urandom));
                    end else if ($urandom_range(0, 3) == 0) begin
                        req_d[i][r] = 1'b1;
                        set_addr(i, r, AW'($urandom));
                    end
                end
            end
            if ($urandom_range(0, 299) == 0) apply_reset();
            else tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
